par2ser: RTL and testbench
==========================

Name: par2ser

Overview:
- Transmit-side counterpart of the GPS character deserializer.
- Captures one parallel latitude/longitude fix of five 7-bit ASCII characters each, then emits it one character at a time over a valid/ready stream to the UART/mobile transmitter.
- Output order: latitude chars, optional separator, longitude chars, optional end-of-line.
- Holds a one-deep pending buffer so a new fix arriving mid-frame is kept, not lost.

Parameters:
- SEP_CHAR, 7'h2C, separator emitted between latitude and longitude (',').
- EOL_CHAR, 7'h0A, terminator emitted after longitude ('\n').
- EN_SEP, 1, 1 = emit SEP_CHAR; 0 = skip it.
- EN_EOL, 1, 1 = emit EOL_CHAR; 0 = skip it.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- data_en  in  1  one-cycle strobe: wei_ch/jing_ch valid this cycle.
- wei_ch  in  35  latitude chars; [34:28] is first char, [6:0] is last.
- jing_ch  in  35  longitude chars, same packing.
- tx_data  out  7  current character.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  downstream accepts when tx_valid & tx_ready.
- busy  out  1  high while a frame is loaded or being sent (ST_SEND).
- frame_done  out  1  one-cycle pulse on the cycle after the last character handshake.
- overrun  out  1  one-cycle pulse when a pending fix is overwritten.

Behaviour:
- Reset (rst low, asynchronous): state = ST_IDLE, index = 0, frame/pending registers = 0, pend_vld = 0; tx_data = 0, tx_valid = 0, busy = 0, frame_done = 0, overrun = 0. Reset mid-frame abandons the frame with no partial continuation.
- Frame length: L = 10 + EN_SEP + EN_EOL.
- Character index sequence:
  - 0..4: wei chars, MSB group first.
  - then SEP_CHAR, if EN_SEP.
  - then 5 jing chars.
  - then EOL_CHAR, if EN_EOL.
- tx_data is a registered or combinational mux of the frame register and index. It must be stable while tx_valid = 1 and no handshake has occurred.
- ST_IDLE:
  - data_en = 1: load wei/jing into the frame register, index = 0, go to ST_SEND.
  - tx_valid rises on the next cycle, with the first char (latency 1 clk from data_en).
- ST_SEND:
  - tx_valid = 1, busy = 1.
  - On handshake with index < L-1: index += 1.
  - On handshake with index = L-1: go to ST_DONE, tx_valid = 0 next cycle.
  - Without tx_ready: hold everything.
- ST_DONE (1 cycle):
  - frame_done = 1, tx_valid = 0.
  - pend_vld = 1: move pending into frame, clear pend_vld, index = 0, go to ST_SEND.
  - Otherwise go to ST_IDLE.
  - A data_en in this same cycle is treated as arriving while busy (pending path).
- data_en while state ≠ ST_IDLE (including the last-handshake cycle and ST_DONE):
  - Write the pending register.
  - If pend_vld was already 1, pulse overrun; latest fix wins.
  - Set pend_vld = 1.
  - The frame in flight is never modified.
- Simultaneous pending promotion in ST_DONE and new data_en:
  - The old pending value goes to the frame.
  - The new value becomes pending, pend_vld = 1, no overrun.
- busy = (state ≠ ST_IDLE).
- Steady-state throughput: one char per clock when tx_ready stays high. Inter-frame gap is 1 cycle (ST_DONE).

Decomposition:
- Shared package constants:
  - State encodings ST_IDLE/ST_SEND/ST_DONE (2-bit).
  - Char width 7.
  - Field width 35.
  - Default SEP/EOL codes (shared with the ser2par side and the display char2num path).
- One natural sub-module: par2ser_charsel, the combinational mux from (frame, index, EN_SEP, EN_EOL) to a 7-bit char.
- FSM, pending buffer and handshake stay in the top.

Test Plan:
- Basic frame: wei_ch = "12345" (0x31..0x35), jing_ch = "67890", tx_ready tied 1, one data_en.
  - Expect tx_valid from the next cycle.
  - Expect tx_data 31,32,33,34,35,2C,36,37,38,39,30,0A on 12 consecutive cycles.
  - Then frame_done pulse; busy falls the cycle after.
- Backpressure: same frame, tx_ready low for 3 cycles at index 5.
  - Expect tx_data = 2C held stable, index frozen, no duplicate or skipped char.
- Pending: second data_en with wei "11111"/jing "22222" at index 3 of the first frame.
  - Expect first frame completes unchanged.
  - Expect frame_done, then second frame starts after a 1-cycle gap.
  - Expect overrun = 0.
- Overrun: two further data_en during one frame ("AAAAA"/"BBBBB", then "CCCCC"/"DDDDD").
  - Expect overrun pulse on the second one.
  - Expect the next frame carries C/D chars only.
- Parameter variants: EN_SEP = 0, EN_EOL = 0.
  - Expect exactly 10 chars 31..35,36..39,30.
  - Expect frame_done after the 10th handshake.
- Async reset: drop rst low at index 7 between clock edges.
  - Expect all outputs 0 immediately, pend_vld cleared.
  - After release, idle until the next data_en.

Source files
------------

// File: rtl/par2ser_pkg.sv
// Shared constants and types for the GPS fix serializer (transmit side).
// SEP/EOL defaults are also used by the ser2par and char2num paths.
package par2ser_pkg;
  localparam int CHAR_W  = 7;
  localparam int FIELD_W = 35;
  localparam int NCHARS  = FIELD_W / CHAR_W;

  localparam logic [CHAR_W-1:0] DEF_SEP = 7'h2C;
  localparam logic [CHAR_W-1:0] DEF_EOL = 7'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] wei;
    logic [FIELD_W-1:0] jing;
  } fix_t;

  function automatic int frame_len(input bit en_sep, input bit en_eol);
    return 2 * NCHARS + int'(en_sep) + int'(en_eol);
  endfunction
endpackage

// File: rtl/par2ser_charsel.sv
// Character selector: maps a frame index onto latitude, separator,
// longitude and end-of-line characters.
module par2ser_charsel
  import par2ser_pkg::*;
#(
  parameter logic [CHAR_W-1:0] SEP_CHAR = DEF_SEP,
  parameter logic [CHAR_W-1:0] EOL_CHAR = DEF_EOL,
  parameter bit                EN_SEP   = 1'b1,
  parameter bit                EN_EOL   = 1'b1
) (
  input  fix_t              frame,
  input  logic [3:0]        idx,
  output logic [CHAR_W-1:0] ch
);
  localparam int JOFF    = NCHARS + int'(EN_SEP);
  localparam int EOL_IDX = JOFF + NCHARS;

  // Skipping the separator shifts longitude down by one slot.
  always_comb begin
    ch = '0;
    for (int i = 0; i < NCHARS; i++) begin
      if (idx == 4'(i))
        ch = frame.wei[(NCHARS-1-i)*CHAR_W +: CHAR_W];
      if (idx == 4'(JOFF + i))
        ch = frame.jing[(NCHARS-1-i)*CHAR_W +: CHAR_W];
    end
    if (EN_SEP && idx == 4'(NCHARS))  ch = SEP_CHAR;
    if (EN_EOL && idx == 4'(EOL_IDX)) ch = EOL_CHAR;
  end
endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial GPS fix transmitter: one frame register, one pending
// fix, valid/ready character stream out.
module par2ser
  import par2ser_pkg::*;
#(
  parameter logic [CHAR_W-1:0] SEP_CHAR = DEF_SEP,
  parameter logic [CHAR_W-1:0] EOL_CHAR = DEF_EOL,
  parameter bit                EN_SEP   = 1'b1,
  parameter bit                EN_EOL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_en,
  input  logic [FIELD_W-1:0] wei_ch,
  input  logic [FIELD_W-1:0] jing_ch,
  output logic [CHAR_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);
  localparam logic [3:0] LAST = 4'(frame_len(EN_SEP, EN_EOL) - 1);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  fix_t       frame_q, frame_d;
  fix_t       pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       tx_valid_q, tx_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       overrun_q, overrun_d;
  logic [CHAR_W-1:0] ch;
  fix_t       in_fix;

  assign in_fix = '{wei: wei_ch, jing: jing_ch};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A fix parked while leaving ST_DONE is still owed a frame.
        if (pend_vld_q) begin
          frame_d    = pend_q;
          pend_vld_d = 1'b0;
          idx_d      = '0;
          state_d    = ST_SEND;
        end else if (data_en) begin
          frame_d = in_fix;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (idx_q == LAST) state_d = ST_DONE;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (pend_vld_q) begin
          frame_d    = pend_q;
          pend_vld_d = 1'b0;
          idx_d      = '0;
          state_d    = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Overrun only when the pending slot is not being drained this cycle.
    if (data_en && (state_q != ST_IDLE || pend_vld_q)) begin
      pend_d     = in_fix;
      pend_vld_d = 1'b1;
      overrun_d  = pend_vld_q && (state_q == ST_SEND);
    end

    tx_valid_d   = (state_d == ST_SEND);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      frame_q      <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      tx_valid_q   <= tx_valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  par2ser_charsel #(
    .SEP_CHAR(SEP_CHAR),
    .EOL_CHAR(EOL_CHAR),
    .EN_SEP  (EN_SEP),
    .EN_EOL  (EN_EOL)
  ) u_charsel (
    .frame(frame_q),
    .idx  (idx_q),
    .ch   (ch)
  );

  assign tx_data    = tx_valid_q ? ch : '0;
  assign tx_valid   = tx_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_par2ser.sv
// Bench for par2ser: queue-based stream model checked every cycle, plus
// literal character sequences and counts per scenario.
module tb_par2ser;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [34:0] wei_ch, jing_ch;
  logic        tx_ready;
  logic [6:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1;
  logic        busy0, busy1;
  logic        fd0, fd1;
  logic        ov0, ov1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  par2ser dut0 (
    .clk(clk), .rst(rst), .data_en(data_en), .wei_ch(wei_ch), .jing_ch(jing_ch),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .busy(busy0), .frame_done(fd0), .overrun(ov0)
  );

  par2ser #(.EN_SEP(1'b0), .EN_EOL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .data_en(data_en), .wei_ch(wei_ch), .jing_ch(jing_ch),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .busy(busy1), .frame_done(fd1), .overrun(ov1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- stream model ----------------
  logic [6:0]  mq[$];
  bit          mdone, mpend, m_ov;
  logic [34:0] mpw, mpj;

  function automatic void mpush(input logic [34:0] w, input logic [34:0] j);
    for (int i = 0; i < 5; i++) mq.push_back(w[34-7*i -: 7]);
    mq.push_back(7'h2C);
    for (int i = 0; i < 5; i++) mq.push_back(j[34-7*i -: 7]);
    mq.push_back(7'h0A);
  endfunction

  initial begin
    mdone = 0; mpend = 0; m_ov = 0; mpw = '0; mpj = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete(); mdone = 0; mpend = 0; m_ov = 0;
      end else begin : step_model
        bit idle_o, send_o, done_o, pend_o;
        logic [34:0] ow, oj;
        send_o = (mq.size() != 0);
        done_o = mdone;
        idle_o = !send_o && !done_o;
        pend_o = mpend; ow = mpw; oj = mpj;
        m_ov = 0;
        if (done_o) begin
          mdone = 0;
          if (pend_o) begin mpush(ow, oj); mpend = 0; end
        end else if (send_o) begin
          if (tx_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) mdone = 1;
          end
        end else if (pend_o) begin
          mpush(ow, oj); mpend = 0;
        end else if (data_en) begin
          mpush(wei_ch, jing_ch);
        end
        if (data_en && (!idle_o || pend_o)) begin
          m_ov  = pend_o && send_o;
          mpend = 1; mpw = wei_ch; mpj = jing_ch;
        end
      end
    end
  end

  // ---------------- compare / log process ----------------
  logic [6:0] log0[$], log1[$];
  int nfd0, nov0, nfd1, hs10_cyc, fd1_cyc;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("tx_valid", tx_valid0, (mq.size() != 0));
        if (mq.size() != 0) chk("tx_data", tx_data0, mq[0]);
        chk("busy", busy0, (mq.size() != 0) || mdone);
        chk("frame_done", fd0, mdone);
        chk("overrun", ov0, m_ov);
        if (tx_valid0 && tx_ready) log0.push_back(tx_data0);
        if (fd0) nfd0++;
        if (ov0) nov0++;
        if (tx_valid1 && tx_ready) begin
          log1.push_back(tx_data1);
          if (log1.size() == 10) hs10_cyc = cyc;
        end
        if (fd1) begin nfd1++; fd1_cyc = cyc; end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [34:0] W12345 = {7'h31, 7'h32, 7'h33, 7'h34, 7'h35};
  localparam logic [34:0] J67890 = {7'h36, 7'h37, 7'h38, 7'h39, 7'h30};
  localparam logic [83:0] E_BASE = {7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h2C,
                                    7'h36, 7'h37, 7'h38, 7'h39, 7'h30, 7'h0A};
  localparam logic [83:0] E_1122 = {{5{7'h31}}, 7'h2C, {5{7'h32}}, 7'h0A};
  localparam logic [83:0] E_CD   = {{5{7'h43}}, 7'h2C, {5{7'h44}}, 7'h0A};
  localparam logic [83:0] E_NOSE = {7'h31, 7'h32, 7'h33, 7'h34, 7'h35,
                                    7'h36, 7'h37, 7'h38, 7'h39, 7'h30, 14'h0};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [34:0] w, input logic [34:0] j);
    data_en = 1'b1; wei_ch = w; jing_ch = j;
    step();
    data_en = 1'b0;
  endtask

  task automatic clr();
    log0.delete(); log1.delete();
    nfd0 = 0; nov0 = 0; nfd1 = 0; hs10_cyc = -1; fd1_cyc = -2;
  endtask

  task automatic chk_seq(input string nm, input int which, input int off, input int n,
                         input logic [83:0] s);
    for (int i = 0; i < n; i++) begin
      logic [6:0] got;
      got = 7'h7F;
      if (which == 0 && off + i < log0.size()) got = log0[off+i];
      if (which == 1 && off + i < log1.size()) got = log1[off+i];
      chk(nm, got, s[83-7*i -: 7]);
    end
  endtask

  initial begin
    rst = 1'b0; data_en = 1'b0; wei_ch = '0; jing_ch = '0; tx_ready = 1'b1;
    clr();
    #1;
    chk("reset tx_valid", tx_valid0, 0);
    chk("reset tx_data", tx_data0, 0);
    chk("reset busy", busy0, 0);
    chk("reset frame_done", fd0, 0);
    chk("reset overrun", ov0, 0);
    chk("reset tx_valid nosep", tx_valid1, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // basic frame, both parameter variants
    clr();
    send(W12345, J67890);
    chk("first valid latency", tx_valid0, 1);
    chk("first char", tx_data0, 7'h31);
    repeat (20) step();
    chk("basic count", log0.size(), 12);
    chk_seq("basic seq", 0, 0, 12, E_BASE);
    chk("basic frame_done count", nfd0, 1);
    chk("nosep count", log1.size(), 10);
    chk_seq("nosep seq", 1, 0, 10, E_NOSE);
    chk("nosep frame_done after 10th", fd1_cyc, hs10_cyc + 1);

    // backpressure at the separator
    clr();
    send(W12345, J67890);
    repeat (5) step();
    tx_ready = 1'b0;
    chk("stall char", tx_data0, 7'h2C);
    repeat (3) begin
      step();
      chk("stall hold data", tx_data0, 7'h2C);
      chk("stall hold valid", tx_valid0, 1);
    end
    tx_ready = 1'b1;
    repeat (20) step();
    chk("bp count", log0.size(), 12);
    chk_seq("bp seq", 0, 0, 12, E_BASE);

    // pending fix mid-frame
    clr();
    send(W12345, J67890);
    repeat (3) step();
    send({5{7'h31}}, {5{7'h32}});
    repeat (40) step();
    chk("pend count", log0.size(), 24);
    chk_seq("pend first", 0, 0, 12, E_BASE);
    chk_seq("pend second", 0, 12, 12, E_1122);
    chk("pend frame_done count", nfd0, 2);
    chk("pend overrun count", nov0, 0);

    // overrun: latest fix wins
    clr();
    send(W12345, J67890);
    repeat (2) step();
    send({5{7'h41}}, {5{7'h42}});
    step();
    send({5{7'h43}}, {5{7'h44}});
    repeat (40) step();
    chk("ovr count", log0.size(), 24);
    chk_seq("ovr first", 0, 0, 12, E_BASE);
    chk_seq("ovr second", 0, 12, 12, E_CD);
    chk("ovr overrun count", nov0, 1);

    // async reset mid-frame with a fix pending
    clr();
    send(W12345, J67890);
    repeat (3) step();
    send({5{7'h31}}, {5{7'h32}});
    repeat (3) step();
    #2 rst = 1'b0;
    #1;
    chk("async tx_valid", tx_valid0, 0);
    chk("async tx_data", tx_data0, 0);
    chk("async busy", busy0, 0);
    chk("async frame_done", fd0, 0);
    chk("async overrun", ov0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    log0.delete();
    repeat (20) step();
    chk("post-reset idle chars", log0.size(), 0);
    chk("post-reset busy", busy0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
